// File: rtl/imem_load_ctrl.sv
// Program-memory port arbiter: CPU fetch in RUN, UART byte-stream loader in LOAD.
// Optional load checksum on ld_sum when IMEM_CHECKSUM_EN is defined.
module imem_load_ctrl #(
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       PC,
   output logic [31:0]       Instruction,
   output logic              cpu_stall,
   input  logic              ld_start,
   input  logic              ld_stop,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              ld_err,
   output logic [31:0]       ld_sum,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_din,
   output logic              ram_we,
   input  logic [31:0]       ram_dout
);

   typedef enum logic [1:0] {S_RUN, S_LOAD, S_FLUSH, S_RESUME} state_t;

   state_t            state_q, state_d;
   logic              boot_q, boot_d;
   logic [1:0]        bidx_q, bidx_d;
   logic [31:0]       buf_q, buf_d;
   logic [ADDR_W-1:0] wcnt_q, wcnt_d;
   logic              full_q, full_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [31:0]       din_q, din_d;
   logic              err_q, err_d;
   logic [31:0]       word_s;
   logic              emit_s;
   logic              emit_wr_s;
   logic              clr_s;
   logic              unused_pc_s;

   always_comb begin
      state_d   = state_q;
      boot_d    = 1'b0;
      bidx_d    = bidx_q;
      buf_d     = buf_q;
      wcnt_d    = wcnt_q;
      full_d    = full_q;
      we_d      = 1'b0;
      waddr_d   = waddr_q;
      din_d     = din_q;
      err_d     = err_q;
      word_s    = buf_q;
      emit_s    = 1'b0;
      emit_wr_s = 1'b0;
      clr_s     = 1'b0;
      case (state_q)
         S_RUN: begin
            if (ld_start) begin
               state_d = S_LOAD;
               clr_s   = 1'b1;
               bidx_d  = 2'd0;
               buf_d   = 32'd0;
               wcnt_d  = {ADDR_W{1'b0}};
               full_d  = 1'b0;
               err_d   = 1'b0;
            end else begin
               state_d = S_RUN;
            end
         end
         S_LOAD: begin
            if (rx_valid) begin
               word_s[{bidx_q, 3'b000} +: 8] = rx_data;
               bidx_d = bidx_q + 2'd1;
               buf_d  = word_s;
               if (bidx_q == 2'd3) begin
                  emit_s = 1'b1;
               end else begin
                  emit_s = 1'b0;
               end
            end else begin
               emit_s = 1'b0;
            end
            // A stop with a partly filled buffer emits the zero-padded word now,
            // so its write lands in the FLUSH cycle.
            if (ld_stop) begin
               state_d = S_FLUSH;
               if (bidx_d != 2'd0) begin
                  emit_s = 1'b1;
               end else begin
                  emit_s = emit_s;
               end
            end else begin
               state_d = S_LOAD;
            end
            if (emit_s || ld_stop) begin
               buf_d  = 32'd0;
               bidx_d = ld_stop ? 2'd0 : bidx_d;
            end else begin
               buf_d  = buf_d;
            end
            if (emit_s) begin
               if (!full_q) begin
                  emit_wr_s = 1'b1;
                  we_d      = 1'b1;
                  waddr_d   = wcnt_q;
                  din_d     = word_s;
                  if (wcnt_q == {ADDR_W{1'b1}}) begin
                     full_d = 1'b1;
                  end else begin
                     wcnt_d = wcnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                  end
               end else begin
                  err_d = 1'b1;
               end
            end else begin
               we_d = 1'b0;
            end
         end
         S_FLUSH:  state_d = S_RESUME;
         S_RESUME: state_d = S_RUN;
         default:  state_d = S_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_RUN;
         boot_q  <= 1'b1;
         bidx_q  <= 2'd0;
         buf_q   <= 32'd0;
         wcnt_q  <= {ADDR_W{1'b0}};
         full_q  <= 1'b0;
         we_q    <= 1'b0;
         waddr_q <= {ADDR_W{1'b0}};
         din_q   <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         boot_q  <= boot_d;
         bidx_q  <= bidx_d;
         buf_q   <= buf_d;
         wcnt_q  <= wcnt_d;
         full_q  <= full_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         din_q   <= din_d;
         err_q   <= err_d;
      end
   end

`ifdef IMEM_CHECKSUM_EN
   logic [31:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (clr_s) begin
         sum_d = 32'd0;
      end else if (emit_wr_s) begin
         sum_d = sum_q + word_s;
      end else begin
         sum_d = sum_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum_q <= 32'd0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign ld_sum = sum_q;
`else
   logic unused_sum_s;
   assign unused_sum_s = clr_s ^ emit_wr_s;
   assign ld_sum = 32'd0;
`endif

   // Write cycles steer the port to the loader; otherwise the PC word address is presented.
   assign ram_addr    = we_q ? waddr_q : PC[ADDR_W+1:2];
   assign ram_we      = we_q;
   assign ram_din     = din_q;
   assign ld_err      = err_q;
   assign cpu_stall   = (state_q != S_RUN) || boot_q;
   assign Instruction = (state_q == S_RUN) ? ram_dout : 32'd0;
   assign unused_pc_s = ^{PC[31:ADDR_W+2], PC[1:0]};

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl with a small synchronous-read memory model (ADDR_W=2).
module tb_imem_load_ctrl;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [31:0]   pc;
   logic [31:0]   instr;
   logic          stall;
   logic          ld_start, ld_stop, rx_valid;
   logic [7:0]    rx_data;
   logic          ld_err;
   logic [31:0]   ld_sum;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_din;
   logic          ram_we;
   logic [31:0]   ram_dout;

   logic [31:0]   mem [0:(1<<AW)-1];
   logic          pre_en;
   logic [AW-1:0] pre_a;
   logic [31:0]   pre_d;
   logic [AW-1:0] wlog_a [$];
   logic [31:0]   wlog_d [$];

   int total = 0;
   int bad   = 0;

   imem_load_ctrl #(.ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .PC(pc), .Instruction(instr), .cpu_stall(stall),
      .ld_start(ld_start), .ld_stop(ld_stop), .rx_valid(rx_valid), .rx_data(rx_data),
      .ld_err(ld_err), .ld_sum(ld_sum), .ram_addr(ram_addr), .ram_din(ram_din),
      .ram_we(ram_we), .ram_dout(ram_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pre_en) begin
         mem[pre_a] <= pre_d;
      end
      if (ram_we) begin
         mem[ram_addr] <= ram_din;
         wlog_a.push_back(ram_addr);
         wlog_d.push_back(ram_din);
      end
      ram_dout <= mem[ram_addr];
   end

   typedef struct {
      logic [31:0] pc;
      logic [31:0] exp_instr;
   } fetch_vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic stop);
      rx_valid = 1'b1;
      rx_data  = b;
      ld_stop  = stop;
      step();
      rx_valid = 1'b0;
      ld_stop  = 1'b0;
   endtask

   task automatic start_load();
      ld_start = 1'b1;
      step();
      ld_start = 1'b0;
   endtask

   fetch_vec_t vecs [5];
   logic [7:0]  s1 [6];
   logic [31:0] w;
   logic [31:0] exp_sum;
   int          n0;

   initial begin
      vecs[0] = '{32'h0000_0008, 32'h00A0_0093};
      vecs[1] = '{32'h0000_0000, 32'h1111_1111};
      vecs[2] = '{32'h0000_0004, 32'h2222_2222};
      vecs[3] = '{32'h0000_000C, 32'h4444_4444};
      vecs[4] = '{32'h0000_0010, 32'h1111_1111};
      s1[0] = 8'h93; s1[1] = 8'h00; s1[2] = 8'hA0;
      s1[3] = 8'h00; s1[4] = 8'h13; s1[5] = 8'h01;

      rst_n = 1'b0; pc = 32'h0000_0008; ld_start = 1'b0; ld_stop = 1'b0;
      rx_valid = 1'b0; rx_data = 8'h00; pre_en = 1'b0; pre_a = '0; pre_d = '0;
      for (int i = 0; i < 4; i++) begin
         pre_en = 1'b1;
         pre_a  = AW'(i);
         pre_d  = (i == 0) ? 32'h1111_1111 : (i == 1) ? 32'h2222_2222 :
                  (i == 2) ? 32'h00A0_0093 : 32'h4444_4444;
         step();
      end
      pre_en = 1'b0;
      step();

      // Reset state
      rst_n = 1'b1;
      chk("reset_stall", {31'd0, stall}, 32'd1);
      chk("reset_we", {31'd0, ram_we}, 32'd0);
      chk("reset_din", ram_din, 32'd0);
      chk("reset_err", {31'd0, ld_err}, 32'd0);
      chk("reset_sum", ld_sum, 32'd0);
      step();
      chk("boot_stall_drop", {31'd0, stall}, 32'd0);
      chk("boot_fetch", instr, 32'h00A0_0093);

      // Fetch table
      for (int i = 0; i < 5; i++) begin
         pc = vecs[i].pc;
         step();
         chk($sformatf("fetch_%0d", i), instr, vecs[i].exp_instr);
         chk($sformatf("fetch_stall_%0d", i), {31'd0, stall}, 32'd0);
      end

      // Ignored pulses in RUN
      ld_stop = 1'b1; rx_valid = 1'b1; rx_data = 8'h55;
      step();
      ld_stop = 1'b0; rx_valid = 1'b0;
      chk("ign_stall", {31'd0, stall}, 32'd0);
      chk("ign_we", {31'd0, ram_we}, 32'd0);

      // Load 6 bytes then stop: one full word plus a padded flush word
      n0 = wlog_a.size();
      start_load();
      chk("load_stall", {31'd0, stall}, 32'd1);
      chk("load_instr", instr, 32'd0);
      for (int i = 0; i < 6; i++) begin
         send(s1[i], 1'b0);
         if (i == 3) begin
            chk("w0_we", {31'd0, ram_we}, 32'd1);
            chk("w0_addr", {30'd0, ram_addr}, 32'd0);
            chk("w0_din", ram_din, 32'h00A0_0093);
         end
      end
      chk("w0_we_one_cycle", {31'd0, ram_we}, 32'd0);
      ld_stop = 1'b1;
      step();
      ld_stop = 1'b0;
      chk("flush_we", {31'd0, ram_we}, 32'd1);
      chk("flush_addr", {30'd0, ram_addr}, 32'd1);
      chk("flush_din", ram_din, 32'h0000_0113);
      chk("flush_stall", {31'd0, stall}, 32'd1);
      step();
      chk("resume_stall", {31'd0, stall}, 32'd1);
      chk("resume_we", {31'd0, ram_we}, 32'd0);
      step();
      chk("run_stall", {31'd0, stall}, 32'd0);
`ifdef IMEM_CHECKSUM_EN
      chk("sum_load1", ld_sum, 32'h00A0_01A6);
`else
      chk("sum_load1", ld_sum, 32'd0);
`endif
      chk("load1_writes", wlog_a.size() - n0, 32'd2);
      pc = 32'h0000_0004;
      step();
      chk("fetch_loaded_w1", instr, 32'h0000_0113);

      // Stop coincident with the 4th byte: exactly one write
      n0 = wlog_a.size();
      start_load();
      send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0);
      send(8'h04, 1'b1);
      chk("cstop_we", {31'd0, ram_we}, 32'd1);
      chk("cstop_din", ram_din, 32'h0403_0201);
      step();
      step();
      step();
      chk("cstop_writes", wlog_a.size() - n0, 32'd1);
      chk("cstop_stall", {31'd0, stall}, 32'd0);

      // Overflow: 5 words into a 4-word memory
      n0 = wlog_a.size();
      exp_sum = 32'd0;
      start_load();
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < 4; i++) begin
            send(8'(16 * k + i), 1'b0);
         end
         if (k < 4) begin
            exp_sum = exp_sum + {8'(16*k+3), 8'(16*k+2), 8'(16*k+1), 8'(16*k)};
         end
      end
      ld_stop = 1'b1;
      step();
      ld_stop = 1'b0;
      chk("ovf_no_flush_we", {31'd0, ram_we}, 32'd0);
      step();
      step();
      chk("ovf_writes", wlog_a.size() - n0, 32'd4);
      for (int k = 0; k < 4; k++) begin
         w = {8'(16*k+3), 8'(16*k+2), 8'(16*k+1), 8'(16*k)};
         if (wlog_a.size() >= n0 + 4) begin
            chk($sformatf("ovf_addr_%0d", k), {30'd0, wlog_a[n0+k]}, k);
            chk($sformatf("ovf_data_%0d", k), wlog_d[n0+k], w);
         end
      end
      chk("ovf_err", {31'd0, ld_err}, 32'd1);
`ifdef IMEM_CHECKSUM_EN
      chk("ovf_sum", ld_sum, exp_sum);
`else
      chk("ovf_sum", ld_sum, 32'd0);
`endif
      step();
      chk("ovf_err_sticky", {31'd0, ld_err}, 32'd1);

      // Reset mid-load
      n0 = wlog_a.size();
      start_load();
      chk("err_cleared", {31'd0, ld_err}, 32'd0);
      send(8'hAA, 1'b0); send(8'hBB, 1'b0);
      rst_n = 1'b0; rx_valid = 1'b1; rx_data = 8'hCC;
      step();
      rst_n = 1'b1; rx_valid = 1'b0;
      chk("rst_stall", {31'd0, stall}, 32'd1);
      chk("rst_we", {31'd0, ram_we}, 32'd0);
      send(8'hDD, 1'b0);
      chk("rst_run_stall", {31'd0, stall}, 32'd0);
      chk("rst_writes", wlog_a.size() - n0, 32'd0);
      start_load();
      send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
      chk("reload_we", {31'd0, ram_we}, 32'd1);
      chk("reload_addr", {30'd0, ram_addr}, 32'd0);
      chk("reload_din", ram_din, 32'h4433_2211);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
